// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: full-speed USB transmit encoder.
// Serializes SYNC, PID, optional payload and CRC16, then EOP, with bit
// stuffing and NRZI encoding onto the D+/D- lines.
// Optional feature macro: USB_TX_CRC16_EN
//   defined   -> CRC16 computed over the payload and sent inverted
//   undefined -> CRC logic removed, CRC field sent as 16'h0000 (bring-up)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | lines at J, waiting for tx_start
// SYNC  | sending 8'h80 LSB first (outside the stuffing domain)
// PID   | sending the packet ID byte
// DATA  | sending payload bytes popped from the data buffer
// CRC   | sending the 16-bit CRC field LSB first
// EOP   | SE0 for two bit times, then J for one bit time
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [1:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);
    localparam int            TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]    MAX_BYTES = 7'(MAX_PAYLOAD);
    localparam logic [1:0]    PKT_ACK   = 2'd0;
    localparam logic [1:0]    PKT_NAK   = 2'd1;
    localparam logic [1:0]    PKT_DATA  = 2'd2;
    localparam logic [1:0]    PKT_STALL = 2'd3;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP} state_t;

    state_t        state_q, state_n;
    logic [TW-1:0] bit_tmr_q;
    logic [15:0]   shreg_q, shreg_n;
    logic [4:0]    bits_left_q, bits_left_n;
    logic [2:0]    ones_q, ones_n;
    logic [6:0]    byte_cnt_q, byte_cnt_n;
    logic [1:0]    pkt_q, pkt_n;
    logic [1:0]    eop_q, eop_n;
    logic          toggle_q, toggle_n;
    logic          err_q, err_n;
    logic          active_q, active_n;
    logic          dp_q, dp_n;
    logic          dm_q, dm_n;
    logic          boundary, pop, ld, go_eop, emit, ebit, stuff_dom;
    logic [15:0]   ld_val;
    logic [4:0]    ld_len;
    logic [15:0]   crc_field;

    function automatic logic [7:0] pid_byte(input logic [1:0] pkt, input logic tgl);
        case (pkt)
            PKT_ACK:   pid_byte = 8'hD2;
            PKT_NAK:   pid_byte = 8'h5A;
            PKT_DATA:  pid_byte = tgl ? 8'h4B : 8'hC3;
            PKT_STALL: pid_byte = 8'h1E;
            default:   pid_byte = 8'h1E;
        endcase
    endfunction

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q, crc_n;

    // Reflected form of x^16+x^15+x^2+1, payload bits taken LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_field = ~crc_q;

    // Running CRC register, seeded on packet start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) crc_q <= 16'hFFFF;
        else        crc_q <= crc_n;
    end
`else
    assign crc_field = 16'h0000;
`endif

    assign stuff_dom = (state_q == PID) || (state_q == DATA) || (state_q == CRC);

    // Next-state: each bit boundary emits a stuff bit, the next shift bit, or opens the next field.
    always_comb begin
        state_n     = state_q;
        shreg_n     = shreg_q;
        bits_left_n = bits_left_q;
        ones_n      = ones_q;
        byte_cnt_n  = byte_cnt_q;
        pkt_n       = pkt_q;
        eop_n       = eop_q;
        toggle_n    = toggle_q;
        err_n       = err_q;
        active_n    = active_q;
        dp_n        = dp_q;
        dm_n        = dm_q;
`ifdef USB_TX_CRC16_EN
        crc_n       = crc_q;
`endif
        boundary    = 1'b0;
        pop         = 1'b0;
        ld          = 1'b0;
        ld_val      = 16'h0000;
        ld_len      = 5'd8;
        go_eop      = 1'b0;
        emit        = 1'b0;
        ebit        = 1'b0;

        if (state_q == IDLE) begin
            if (tx_start) begin
                boundary   = 1'b1;
                state_n    = SYNC;
                active_n   = 1'b1;
                err_n      = 1'b0;
                pkt_n      = tx_packet;
                byte_cnt_n = (buffer_occupancy > MAX_BYTES) ? MAX_BYTES : buffer_occupancy;
`ifdef USB_TX_CRC16_EN
                crc_n      = 16'hFFFF;
`endif
                ld         = 1'b1;
                ld_val     = 16'h0080;
            end
        end else if (bit_tmr_q == '0) begin
            boundary = 1'b1;
            if (stuff_dom && (ones_q == 3'd6)) begin
                emit = 1'b1;
            end else if (bits_left_q != 5'd0) begin
                emit        = 1'b1;
                ebit        = shreg_q[0];
                shreg_n     = shreg_q >> 1;
                bits_left_n = bits_left_q - 5'd1;
            end else begin
                case (state_q)
                    SYNC: begin
                        state_n = PID;
                        ld      = 1'b1;
                        ld_val  = {8'h00, pid_byte(pkt_q, toggle_q)};
                    end
                    PID, DATA: begin
                        if (pkt_q != PKT_DATA) begin
                            go_eop = 1'b1;
                        end else if (byte_cnt_q == 7'd0) begin
                            state_n = CRC;
                            ld      = 1'b1;
                            ld_val  = crc_field;
                            ld_len  = 5'd16;
                        end else if (buffer_occupancy == 7'd0) begin
                            // underflow: abandon payload, no CRC
                            err_n  = 1'b1;
                            go_eop = 1'b1;
                        end else begin
                            state_n    = DATA;
                            ld         = 1'b1;
                            ld_val     = {8'h00, tx_packet_data};
                            pop        = 1'b1;
                            byte_cnt_n = byte_cnt_q - 7'd1;
`ifdef USB_TX_CRC16_EN
                            crc_n      = crc16_byte(crc_q, tx_packet_data);
`endif
                        end
                    end
                    CRC: go_eop = 1'b1;
                    EOP: begin
                        if (eop_q == 2'd0) begin
                            eop_n = 2'd1;
                        end else if (eop_q == 2'd1) begin
                            eop_n = 2'd2;
                            dp_n  = 1'b1;
                            dm_n  = 1'b0;
                        end else begin
                            state_n  = IDLE;
                            active_n = 1'b0;
                            if ((pkt_q == PKT_DATA) && !err_q) toggle_n = ~toggle_q;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        if (ld) begin
            emit        = 1'b1;
            ebit        = ld_val[0];
            shreg_n     = ld_val >> 1;
            bits_left_n = ld_len - 5'd1;
        end
        if (go_eop) begin
            state_n = EOP;
            eop_n   = 2'd0;
            dp_n    = 1'b0;
            dm_n    = 1'b0;
        end
        if (emit) begin
            if (!ebit) begin
                dp_n = dm_q;
                dm_n = dp_q;
            end
            ones_n = (ebit && ((state_n == PID) || (state_n == DATA) || (state_n == CRC)))
                     ? ones_q + 3'd1 : 3'd0;
        end
    end

    // Bit timer: down-counter reloaded at every bit boundary.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                bit_tmr_q <= BIT_LAST;
        else if (boundary)         bit_tmr_q <= BIT_LAST;
        else if (state_q != IDLE)  bit_tmr_q <= bit_tmr_q - 1'b1;
    end

    // State and registered line outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            shreg_q     <= 16'h0000;
            bits_left_q <= 5'd0;
            ones_q      <= 3'd0;
            byte_cnt_q  <= 7'd0;
            pkt_q       <= PKT_ACK;
            eop_q       <= 2'd0;
            toggle_q    <= 1'b0;
            err_q       <= 1'b0;
            active_q    <= 1'b0;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
        end else begin
            state_q     <= state_n;
            shreg_q     <= shreg_n;
            bits_left_q <= bits_left_n;
            ones_q      <= ones_n;
            byte_cnt_q  <= byte_cnt_n;
            pkt_q       <= pkt_n;
            eop_q       <= eop_n;
            toggle_q    <= toggle_n;
            err_q       <= err_n;
            active_q    <= active_n;
            dp_q        <= dp_n;
            dm_q        <= dm_n;
        end
    end

    assign get_tx_packet_data = pop;
    assign tx_transfer_active = active_q;
    assign tx_error           = err_q;
    assign dplus_out          = dp_q;
    assign dminus_out         = dm_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Testbench for usb_tx_encoder: vector table of packets plus hand-written
// busy-start and mid-packet-reset sequences. Expected line symbols are built
// from the packet contents and checked per clock against D+/D-.
module tb_usb_tx_encoder;
    localparam int CPB  = 4;
    localparam int MAXP = 64;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [1:0] tx_packet = 2'd0;
    logic [6:0] occ = 7'd0;
    logic [7:0] head = 8'h00;
    logic       get_tx_packet_data, tx_transfer_active, tx_error, dplus_out, dminus_out;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MAXP)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (occ),
        .tx_packet_data     (head),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    // Data buffer model: refilled on request, popped on get_tx_packet_data.
    logic [7:0] fill_data [0:79];
    int         fill_len = 0;
    logic       fill_req = 1'b0;
    logic       flush_after_pop = 1'b0;
    logic [7:0] buf_q [$];
    int         pop_cnt = 0;
    int         wide_pops = 0;
    logic       get_d = 1'b0;

    // Buffer behaviour seen by the DUT, plus pop counting.
    always @(posedge clk) begin
        if (get_tx_packet_data) pop_cnt <= pop_cnt + 1;
        if (get_tx_packet_data && get_d) wide_pops <= wide_pops + 1;
        get_d <= get_tx_packet_data;
        if (fill_req) begin
            buf_q.delete();
            for (int i = 0; i < fill_len; i++) buf_q.push_back(fill_data[i]);
        end else if (get_tx_packet_data && (buf_q.size() > 0)) begin
            buf_q.delete(0);
            if (flush_after_pop) buf_q.delete();
        end
        occ  <= 7'(buf_q.size());
        head <= (buf_q.size() > 0) ? buf_q[0] : 8'h00;
    end

    // Scoreboard of expected {D+,D-} per bit time.
    logic [1:0] exp_q [$];

    task automatic fill_buffer(input int n, input bit all_ff, input bit flush);
        for (int i = 0; i < n; i++) fill_data[i] = all_ff ? 8'hFF : 8'($urandom_range(0, 255));
        fill_len        = n;
        flush_after_pop = flush;
        fill_req        = 1'b1;
        @(negedge clk);
        fill_req        = 1'b0;
    endtask

    task automatic build_expected(input logic [7:0] pid, input int nsend, input bit with_crc);
        bit          dom [$];
        bit          stf [$];
        logic [7:0]  sync_b;
        logic [7:0]  b;
        logic [15:0] crc;
        logic [15:0] cfield;
        logic [1:0]  line;
        logic        fb;
        int          run;
        sync_b = 8'h80;
        crc    = 16'hFFFF;
        for (int i = 0; i < 8; i++) dom.push_back(pid[i]);
        for (int k = 0; k < nsend; k++) begin
            b = fill_data[k];
            for (int i = 0; i < 8; i++) begin
                dom.push_back(b[i]);
                fb  = crc[0] ^ b[i];
                crc = crc >> 1;
                if (fb) crc = crc ^ 16'hA001;
            end
        end
`ifdef USB_TX_CRC16_EN
        cfield = ~crc;
`else
        cfield = 16'h0000;
`endif
        if (with_crc) for (int i = 0; i < 16; i++) dom.push_back(cfield[i]);
        run = 0;
        foreach (dom[i]) begin
            stf.push_back(dom[i]);
            run = dom[i] ? run + 1 : 0;
            if (run == 6) begin
                stf.push_back(1'b0);
                run = 0;
            end
        end
        exp_q.delete();
        line = 2'b10;
        for (int i = 0; i < 8; i++) begin
            if (!sync_b[i]) line = {line[0], line[1]};
            exp_q.push_back(line);
        end
        foreach (stf[i]) begin
            if (!stf[i]) line = {line[0], line[1]};
            exp_q.push_back(line);
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    // Send one packet and check every clock of it; returns in the first idle cycle.
    task automatic run_packet(input int tag, input logic [1:0] pkt, input int nfill, input bit all_ff,
                              input bit flush, input logic [7:0] pid, input int exp_pops,
                              input bit exp_err, input int exp_clks, input int busy_at);
        int         cnt, nsend, nclk, act_cnt, p0;
        bit         under;
        logic [1:0] sym;
        if (pkt == 2'd2) fill_buffer(nfill, all_ff, flush);
        cnt   = (pkt == 2'd2) ? ((nfill > MAXP) ? MAXP : nfill) : 0;
        under = flush && (cnt > 1);
        nsend = under ? 1 : cnt;
        build_expected(pid, nsend, (pkt == 2'd2) && !under);
        nclk    = exp_q.size() * CPB;
        act_cnt = 0;
        sym     = 2'b10;
        p0      = pop_cnt;
        tx_packet = pkt;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        check($sformatf("err_clear p%0d", tag), 32'(tx_error), 32'd0);
        for (int c = 0; c < nclk; c++) begin
            if ((c % CPB) == 0) sym = exp_q.pop_front();
            check($sformatf("line p%0d bit%0d clk%0d", tag, c / CPB, c % CPB),
                  32'({dplus_out, dminus_out}), 32'(sym));
            if (tx_transfer_active) act_cnt++;
            if ((busy_at > 0) && (c == busy_at)) begin
                tx_packet = 2'd3;
                tx_start  = 1'b1;
            end
            if ((busy_at > 0) && (c == busy_at + 1)) tx_start = 1'b0;
            @(negedge clk);
        end
        check($sformatf("active_end p%0d", tag), 32'(tx_transfer_active), 32'd0);
        check($sformatf("active_len p%0d", tag), 32'(act_cnt), 32'(nclk));
        if (exp_clks > 0) check($sformatf("active_clks p%0d", tag), 32'(act_cnt), 32'(exp_clks));
        check($sformatf("pops p%0d", tag), 32'(pop_cnt - p0), 32'(exp_pops));
        check($sformatf("err p%0d", tag), 32'(tx_error), 32'(exp_err));
    endtask

    typedef struct {
        logic [1:0] pkt;
        int         nfill;
        bit         all_ff;
        bit         flush;
        logic [7:0] pid;
        int         pops;
        bit         err;
        int         clks;
    } vec_t;

    vec_t vecs [0:10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // pkt nfill ff flush pid pops err clks ; toggle expectation encoded in pid
        vecs[0]  = '{2'd0, 0,  1'b0, 1'b0, 8'hD2, 0,  1'b0, 76};   // ACK
        vecs[1]  = '{2'd1, 0,  1'b0, 1'b0, 8'h5A, 0,  1'b0, 76};   // NAK back-to-back
        vecs[2]  = '{2'd3, 0,  1'b0, 1'b0, 8'h1E, 0,  1'b0, 76};   // STALL
        vecs[3]  = '{2'd2, 0,  1'b0, 1'b0, 8'hC3, 0,  1'b0, 140};  // zero-length DATA0
        vecs[4]  = '{2'd2, 1,  1'b1, 1'b0, 8'h4B, 1,  1'b0, 0};    // DATA1, FF payload
        vecs[5]  = '{2'd2, 3,  1'b0, 1'b0, 8'hC3, 3,  1'b0, 0};
        vecs[6]  = '{2'd2, 3,  1'b0, 1'b1, 8'h4B, 1,  1'b1, 0};    // underflow
        vecs[7]  = '{2'd2, 2,  1'b0, 1'b0, 8'h4B, 2,  1'b0, 0};    // same PID, err clears
        vecs[8]  = '{2'd2, 70, 1'b0, 1'b0, 8'hC3, 64, 1'b0, 0};    // clipped to MAX_PAYLOAD
        vecs[9]  = '{2'd0, 0,  1'b0, 1'b0, 8'hD2, 0,  1'b0, 76};
        vecs[10] = '{2'd2, 1,  1'b1, 1'b0, 8'h4B, 1,  1'b0, 0};

        repeat (3) @(negedge clk);
        check("rst dplus",  32'(dplus_out),          32'd1);
        check("rst dminus", 32'(dminus_out),         32'd0);
        check("rst active", 32'(tx_transfer_active), 32'd0);
        check("rst error",  32'(tx_error),           32'd0);
        check("rst get",    32'(get_tx_packet_data), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            run_packet(v, vecs[v].pkt, vecs[v].nfill, vecs[v].all_ff, vecs[v].flush,
                       vecs[v].pid, vecs[v].pops, vecs[v].err, vecs[v].clks, 0);
        end

        // DATA0 with FF payload: PID C3 ends in two 1s, so the stuff 0 follows the
        // sixth consecutive 1, which is the fourth payload bit.
        run_packet(20, 2'd2, 1, 1'b1, 1'b0, 8'hC3, 1, 1'b0, 0, 0);

        // Busy start during PID on an underflowing packet: ignored, error stays set.
        run_packet(21, 2'd2, 3, 1'b0, 1'b1, 8'h4B, 1, 1'b1, 0, 10 * CPB);
        repeat (4) @(negedge clk);
        check("busy idle", 32'(tx_transfer_active), 32'd0);

        // Reset in the middle of a DATA1 payload.
        fill_buffer(3, 1'b0, 1'b0);
        tx_packet = 2'd2;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        check("pre_rst active", 32'(tx_transfer_active), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst dplus",  32'(dplus_out),          32'd1);
        check("mid_rst dminus", 32'(dminus_out),         32'd0);
        check("mid_rst active", 32'(tx_transfer_active), 32'd0);
        check("mid_rst get",    32'(get_tx_packet_data), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Toggle back at DATA0 after reset, then DATA1.
        run_packet(22, 2'd2, 1, 1'b1, 1'b0, 8'hC3, 1, 1'b0, 0, 0);
        run_packet(23, 2'd2, 1, 1'b1, 1'b0, 8'h4B, 1, 1'b0, 0, 0);

        check("pop width", 32'(wide_pops), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
